tick_gen: RTL

TICK_GEN -- requirements
Module: tick_gen

---
 rtl/tick_gen_pkg.sv | 13 +
 rtl/edge_rise.sv | 27 ++
 rtl/tick_gen.sv | 107 ++++++++++
 3 files changed

// File: rtl/tick_gen_pkg.sv
// Shared constants for the tick generator: run-mode encodings and the board clock.
package tick_gen_pkg;

   typedef enum logic [1:0] {
      MODE_HALT = 2'b00,
      MODE_RUN  = 2'b01,
      MODE_STEP = 2'b10
   } mode_e;

   // TinyFPGA BX on-board oscillator.
   localparam int unsigned TINYFPGA_BX_CLK = 16_000_000;

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector; the pulse follows the sampling edge by one cycle.
module edge_rise (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   input  logic i_sig,
   output logic o_rise
);

   logic prev_q;
   logic rise_q;

   // prev_q tracks the input in every mode, so a level raised while disabled
   // is already "old" by the time the detector is enabled.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         prev_q <= i_sig;
         rise_q <= i_en & i_sig & ~prev_q;
      end
   end

   assign o_rise = rise_q;

endmodule

// File: rtl/tick_gen.sv
// Programmable tick / square-wave generator with HALT, RUN and single-STEP modes.
module tick_gen
   import tick_gen_pkg::*;
#(
   parameter int unsigned INPUT_CLOCK  = TINYFPGA_BX_CLK,
   parameter int unsigned OUTPUT_CLOCK = 1,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [1:0]       i_mode,
   input  logic             i_step,
   input  logic             i_div_load,
   input  logic [CNT_W-1:0] i_div,
   output logic             o_div_ack,
   output logic             o_div_err,
   output logic             o_tick,
   output logic             o_square,
   output logic             o_running,
   output logic [15:0]      o_tick_count
);

   localparam int unsigned      HALF_RST_I = INPUT_CLOCK / (2 * OUTPUT_CLOCK);
   localparam logic [CNT_W-1:0] HALF_RST   = CNT_W'(HALF_RST_I);

   logic [CNT_W-1:0] hp_q, hp_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sq_q, sq_d;
   logic [15:0]      tc_q, tc_d;
   logic             tick_q, tick_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic             run_q;
   logic             mode_run, mode_step, terminal, step_pulse;

   assign mode_run  = (i_mode == MODE_RUN);
   assign mode_step = (i_mode == MODE_STEP);
   assign terminal  = (cnt_q == hp_q - CNT_W'(1));

   edge_rise u_step_edge (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (mode_step),
      .i_sig   (i_step),
      .o_rise  (step_pulse)
   );

   always_comb begin
      hp_d   = hp_q;
      cnt_d  = cnt_q;
      sq_d   = sq_q;
      tick_d = 1'b0;
      ack_d  = 1'b0;
      err_d  = 1'b0;
      // An accepted load restarts the phase and pre-empts any tick this cycle.
      if (i_div_load && (i_div != '0)) begin
         hp_d  = i_div;
         cnt_d = '0;
         sq_d  = 1'b0;
         ack_d = 1'b1;
      end else begin
         err_d = i_div_load;
         if (mode_run) begin
            if (terminal) begin
               cnt_d  = '0;
               sq_d   = ~sq_q;
               tick_d = ~sq_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else if (mode_step) begin
            tick_d = step_pulse;
         end
      end
      tc_d = tc_q + {15'd0, tick_d};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hp_q   <= HALF_RST;
         cnt_q  <= '0;
         sq_q   <= 1'b0;
         tc_q   <= '0;
         tick_q <= 1'b0;
         ack_q  <= 1'b0;
         err_q  <= 1'b0;
         run_q  <= 1'b0;
      end else begin
         hp_q   <= hp_d;
         cnt_q  <= cnt_d;
         sq_q   <= sq_d;
         tc_q   <= tc_d;
         tick_q <= tick_d;
         ack_q  <= ack_d;
         err_q  <= err_d;
         run_q  <= mode_run;
      end
   end

   assign o_tick       = tick_q;
   assign o_square     = sq_q;
   assign o_tick_count = tc_q;
   assign o_div_ack    = ack_q;
   assign o_div_err    = err_q;
   assign o_running    = run_q;

endmodule
